// File: rtl/alu_pkg.sv
// Shared ALU definitions: adder width limit and register reset values.
package alu_pkg;

    localparam int unsigned ADDER_MAX_WIDTH = 64;

    localparam logic SUM_RST_BIT = 1'b0;
    localparam logic CARRY_RST   = 1'b0;

    // Reset pattern for a sum register of the given width.
    function automatic logic [ADDER_MAX_WIDTH-1:0] sum_rst_value();
        return {ADDER_MAX_WIDTH{SUM_RST_BIT}};
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit combinational full adder: the ripple-chain cell of simple_adder.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/simple_adder.sv
// Registered WIDTH-bit ripple-carry adder; sum/carry appear one clock after an in_valid capture.
module simple_adder
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             out_valid
);

    localparam logic [ADDER_MAX_WIDTH-1:0] SUM_RST_FULL = sum_rst_value();
    localparam logic [WIDTH-1:0]           SUM_RST      = SUM_RST_FULL[WIDTH-1:0];

    logic [WIDTH:0]   chain_c;
    logic [WIDTH-1:0] sum_c;

    assign chain_c[0] = ci;

    // Ripple chain: cell i consumes carry i and produces carry i+1.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (chain_c[i]),
            .s  (sum_c[i]),
            .co (chain_c[i+1])
        );
    end

    // Result register: loads only on capture, holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum   <= SUM_RST;
            carry <= CARRY_RST;
        end else if (in_valid) begin
            sum   <= sum_c;
            carry <= chain_c[WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_simple_adder.sv
// Scoreboard bench for simple_adder at WIDTH=1 and WIDTH=8 sharing one clock and reset.
module tb_simple_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [0:0] a1, b1, s1;
    logic       ci1, co1, ov1;
    logic [7:0] a8, b8, s8;
    logic       ci8, co8, ov8;

    int checks = 0;
    int errors = 0;

    logic [1:0] q1[$];
    logic [8:0] q8[$];
    logic [1:0] last1;
    logic [8:0] last8;
    logic [1:0] tt[8];

    always #5 clk = ~clk;

    simple_adder #(.WIDTH(1)) d1 (
        .a(a1), .b(b1), .ci(ci1), .sum(s1), .carry(co1),
        .clk(clk), .rst(rst), .in_valid(in_valid), .out_valid(ov1)
    );

    simple_adder #(.WIDTH(8)) d8 (
        .a(a8), .b(b8), .ci(ci8), .sum(s8), .carry(co8),
        .clk(clk), .rst(rst), .in_valid(in_valid), .out_valid(ov8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one capture on both DUTs and queue the reference results.
    task automatic drive(input logic xa1, input logic xb1, input logic xc1,
                         input logic [7:0] xa8, input logic [7:0] xb8, input logic xc8);
        a1 = xa1; b1 = xb1; ci1 = xc1;
        a8 = xa8; b8 = xb8; ci8 = xc8;
        in_valid = 1'b1;
        q1.push_back(tt[{xa1, xb1, xc1}]);
        q8.push_back(9'(xa8) + 9'(xb8) + 9'(xc8));
    endtask

    // Advance one edge and compare both DUT outputs against the queue heads.
    task automatic expect_out(input string tag);
        cycle();
        if (q1.size() == 0 || q8.size() == 0) begin
            check({tag, "_queue"}, 64'(q1.size() + q8.size()), 64'd2);
        end else begin
            last1 = q1.pop_front();
            last8 = q8.pop_front();
            check({tag, "_w1_res"}, 64'({co1, s1}), 64'(last1));
            check({tag, "_w1_ov"},  64'(ov1), 64'd1);
            check({tag, "_w8_res"}, 64'({co8, s8}), 64'(last8));
            check({tag, "_w8_ov"},  64'(ov8), 64'd1);
        end
    endtask

    task automatic expect_idle(input string tag, input logic [1:0] e1, input logic [8:0] e8);
        check({tag, "_w1_res"}, 64'({co1, s1}), 64'(e1));
        check({tag, "_w1_ov"},  64'(ov1), 64'd0);
        check({tag, "_w8_res"}, 64'({co8, s8}), 64'(e8));
        check({tag, "_w8_ov"},  64'(ov8), 64'd0);
    endtask

    initial begin
        // WIDTH=1 truth table indexed by {a,b,ci}, value {carry,sum}.
        tt[0] = 2'b00; tt[1] = 2'b01; tt[2] = 2'b01; tt[3] = 2'b10;
        tt[4] = 2'b01; tt[5] = 2'b10; tt[6] = 2'b10; tt[7] = 2'b11;

        // Reset with inputs active: nothing may be captured.
        rst = 1'b1; in_valid = 1'b1;
        a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
        a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b1;
        #2;
        expect_idle("rst_async", 2'b00, 9'h000);
        cycle();
        cycle();
        expect_idle("rst_held", 2'b00, 9'h000);
        rst = 1'b0;

        // Exhaustive single-bit table, 8-bit lane random alongside.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            drive(v[1], v[0], v[2], 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            expect_out($sformatf("tt%0d", i));
        end

        // 8-bit wrap-around cases.
        drive(1'b1, 1'b0, 1'b0, 8'hFF, 8'h01, 1'b0);
        expect_out("wrap_ff01");
        check("wrap_ff01_lit", 64'({co8, s8}), 64'h100);
        drive(1'b0, 1'b0, 1'b0, 8'h7F, 8'h00, 1'b1);
        expect_out("wrap_7f00");
        check("wrap_7f00_lit", 64'({co8, s8}), 64'h080);

        // Register carry=1,sum=1 then pulse reset between edges.
        drive(1'b1, 1'b1, 1'b1, 8'hF0, 8'h0F, 1'b1);
        expect_out("pre_rst");
        check("pre_rst_lit", 64'({co1, s1}), 64'h3);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        expect_idle("mid_rst", 2'b00, 9'h000);
        #1;
        rst = 1'b0;
        cycle();
        expect_idle("post_rst", 2'b00, 9'h000);

        // Capture 0+1+1, then hold through toggling inputs.
        drive(1'b0, 1'b1, 1'b1, 8'h12, 8'h34, 1'b0);
        expect_out("hold_cap");
        check("hold_cap_lit", 64'({co1, s1}), 64'h2);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a1 = ~a1; b1 = ~b1; ci1 = ~ci1;
            a8 = ~a8; b8 = 8'($urandom_range(0, 255)); ci8 = ~ci8;
            cycle();
            expect_idle($sformatf("hold%0d", i), 2'b10, last8);
        end

        // Back-to-back stream: one result per cycle, out_valid continuous.
        drive(1'b0, 1'b0, 1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 100; i++) begin
            cycle();
            last1 = q1.pop_front();
            last8 = q8.pop_front();
            check("stream_w8_res", 64'({co8, s8}), 64'(last8));
            check("stream_w8_ov",  64'(ov8), 64'd1);
            check("stream_w1_res", 64'({co1, s1}), 64'(last1));
            if (i < 99) begin
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            end else begin
                in_valid = 1'b0;
            end
        end
        cycle();
        expect_idle("stream_end", last1, last8);
        check("queue_drained", 64'(q1.size() + q8.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
